sw_event_sequencer: RTL and testbench



---
 rtl/sw_event_pkg.sv | 28 ++
 rtl/sw_event_fifo.sv | 64 ++++++
 rtl/sw_event_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_sw_event_sequencer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_event_pkg.sv
// Shared types and constants for the switch-PIO event sequencer.
package sw_event_pkg;

    localparam int unsigned SW_N_SW       = 18;
    localparam int unsigned SW_IDX_W      = 5;
    localparam int unsigned SW_FIFO_DEPTH = 8;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT_MASK,
        ST_IDLE,
        ST_RD_CAP,
        ST_CAP_WAIT,
        ST_CLR,
        ST_RD_LVL,
        ST_LVL_WAIT,
        ST_EMIT
    } state_e;

    typedef struct packed {
        logic [SW_IDX_W-1:0] index;
        logic                level;
    } ev_rec_t;

endpackage

// File: rtl/sw_event_fifo.sv
// Synchronous event FIFO; push and pop may coincide, including when full.
module sw_event_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             push_ok, pop_ok;

    assign pop_ok  = pop & ~empty_q;
    assign push_ok = push & (~full_q | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
        if (pop_ok)  rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
        cnt_d   = CNT_W'(cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok));
        full_d  = (cnt_d == CNT_W'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: contents are only visible while not empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/sw_event_sequencer.sv
// Services the switch PIO interrupt and turns captured edges into an event stream.
// Optional SW_EVT_OVERFLOW_EN: drop events on a full FIFO and count them in ev_dropped.
module sw_event_sequencer
    import sw_event_pkg::*;
#(
    parameter int unsigned     N_SW       = SW_N_SW,
    parameter int unsigned     IDX_W      = SW_IDX_W,
    parameter int unsigned     FIFO_DEPTH = SW_FIFO_DEPTH,
    parameter logic [N_SW-1:0] MASK_INIT  = N_SW'(32'h3FFFF)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       pio_address,
    output logic             pio_chipselect,
    output logic             pio_write_n,
    output logic [31:0]      pio_writedata,
    input  logic [31:0]      pio_readdata,
    input  logic             pio_irq,
    input  logic             enable,
    input  logic             cfg_mask_wr,
    input  logic [N_SW-1:0]  cfg_mask,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDX_W-1:0] ev_index,
    output logic             ev_level,
    output logic             busy
`ifdef SW_EVT_OVERFLOW_EN
   ,output logic [15:0]      ev_dropped
`endif
);

    localparam int unsigned EV_W = IDX_W + 1;

    state_e            state_q, state_d;
    logic [N_SW-1:0]   pending_q, pending_d;
    logic [N_SW-1:0]   level_q, level_d;
    logic [N_SW-1:0]   mask_q, mask_d;
    logic [N_SW-1:0]   req_mask_q, req_mask_d;
    logic              req_q, req_d;
    logic              cs_q, cs_d, wn_q, wn_d, busy_q, busy_d;
    logic [1:0]        addr_q, addr_d;
    logic [31:0]       wd_q, wd_d;
    logic [IDX_W-1:0]  low_idx;
    logic [N_SW-1:0]   low_bit;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty, can_push;
    logic [EV_W-1:0]   fifo_rd_data;
    logic              rd_unused_c;
`ifdef SW_EVT_OVERFLOW_EN
    logic [15:0]       drop_q, drop_d;
`endif

    assign rd_unused_c = ^pio_readdata[31:N_SW];

    // Lowest set bit of the pending word; later iterations win.
    always_comb begin
        low_idx = '0;
        for (int i = int'(N_SW) - 1; i >= 0; i--) begin
            if (pending_q[i]) low_idx = IDX_W'(i);
        end
    end

    assign low_bit  = N_SW'(1) << low_idx;
    assign fifo_pop = ~fifo_empty & ev_ready;
    assign can_push = ~fifo_full | fifo_pop;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        level_d    = level_q;
        mask_d     = mask_q;
        req_d      = req_q;
        req_mask_d = req_mask_q;
        fifo_push  = 1'b0;
`ifdef SW_EVT_OVERFLOW_EN
        drop_d     = drop_q;
`endif
        // Most recent mask request wins; applied on the next IDLE.
        if (cfg_mask_wr) begin
            req_d      = 1'b1;
            req_mask_d = cfg_mask;
        end

        case (state_q)
            ST_INIT_MASK: state_d = cs_q ? ST_IDLE : ST_INIT_MASK;
            ST_IDLE: begin
                if (req_q) begin
                    state_d = ST_INIT_MASK;
                    mask_d  = req_mask_q;
                    req_d   = cfg_mask_wr;
                end else if (pio_irq && enable) begin
                    state_d = ST_RD_CAP;
                end
            end
            ST_RD_CAP:   state_d = ST_CAP_WAIT;
            ST_CAP_WAIT: begin
                pending_d = pio_readdata[N_SW-1:0];
                state_d   = ST_CLR;
            end
            ST_CLR:      state_d = ST_RD_LVL;
            ST_RD_LVL:   state_d = ST_LVL_WAIT;
            ST_LVL_WAIT: begin
                level_d = pio_readdata[N_SW-1:0];
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (pending_q != '0) begin
`ifdef SW_EVT_OVERFLOW_EN
                    pending_d = pending_q & ~low_bit;
                    if (can_push)               fifo_push = 1'b1;
                    else if (drop_q != 16'hFFFF) drop_d   = drop_q + 16'd1;
`else
                    if (can_push) begin
                        fifo_push = 1'b1;
                        pending_d = pending_q & ~low_bit;
                    end
`endif
                end
                state_d = (pending_d == '0) ? ST_IDLE : ST_EMIT;
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus outputs are registered from the state being entered.
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = PIO_ADDR_DATA;
        wd_d   = '0;
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_INIT_MASK: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = PIO_ADDR_MASK;
                wd_d   = 32'(mask_d);
            end
            ST_RD_CAP, ST_CAP_WAIT: addr_d = PIO_ADDR_EDGE;
            ST_CLR: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = PIO_ADDR_EDGE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT_MASK;
            pending_q  <= '0;
            level_q    <= '0;
            mask_q     <= MASK_INIT;
            req_q      <= 1'b0;
            req_mask_q <= '0;
            cs_q       <= 1'b0;
            wn_q       <= 1'b1;
            addr_q     <= PIO_ADDR_DATA;
            wd_q       <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            level_q    <= level_d;
            mask_q     <= mask_d;
            req_q      <= req_d;
            req_mask_q <= req_mask_d;
            cs_q       <= cs_d;
            wn_q       <= wn_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            busy_q     <= busy_d;
        end
    end

`ifdef SW_EVT_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (reset) drop_q <= '0;
        else       drop_q <= drop_d;
    end
    assign ev_dropped = drop_q;
`endif

    sw_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({low_idx, level_q[low_idx]}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pio_address    = addr_q;
    assign pio_chipselect = cs_q;
    assign pio_write_n    = wn_q;
    assign pio_writedata  = wd_q;
    assign busy           = busy_q;
    assign ev_valid       = ~fifo_empty;
    assign ev_index       = fifo_rd_data[EV_W-1:1];
    assign ev_level       = fifo_rd_data[0];

endmodule

// File: tb/tb_sw_event_sequencer.sv
// Self-checking bench: PIO register model plus event-list reference model.
module tb_sw_event_sequencer;
    import sw_event_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pio_address;
    logic        pio_chipselect, pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata = '0;
    logic        pio_irq;
    logic        enable = 1'b1;
    logic        cfg_mask_wr = 1'b0;
    logic [17:0] cfg_mask = '0;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic [4:0]  ev_index;
    logic        ev_level;
    logic        busy;
`ifdef SW_EVT_OVERFLOW_EN
    logic [15:0] ev_dropped;
`endif

    int checks = 0;
    int errors = 0;

    logic [17:0] sw_level  = '0;
    logic [17:0] edge_cap  = '0;
    logic [17:0] pio_mask  = '0;
    logic [17:0] inject    = '0;
    logic [17:0] last_mask = '0;
    logic        irq_force = 1'b0;
    int          mask_cnt  = 0;
    int          clr_cnt   = 0;

    ev_rec_t got[$];
    ev_rec_t exp_q[$];
    ev_rec_t mon_r;

    always #5 clk = ~clk;

    sw_event_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .pio_irq        (pio_irq),
        .enable         (enable),
        .cfg_mask_wr    (cfg_mask_wr),
        .cfg_mask       (cfg_mask),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_index       (ev_index),
        .ev_level       (ev_level),
        .busy           (busy)
`ifdef SW_EVT_OVERFLOW_EN
       ,.ev_dropped     (ev_dropped)
`endif
    );

    // PIO slave model: registered read data, mask register, edge capture.
    always @(posedge clk) begin
        case (pio_address)
            2'd0:    pio_readdata <= {14'd0, sw_level};
            2'd2:    pio_readdata <= {14'd0, pio_mask};
            2'd3:    pio_readdata <= {14'd0, edge_cap};
            default: pio_readdata <= 32'd0;
        endcase
        if (pio_chipselect && !pio_write_n && pio_address == 2'd2) begin
            pio_mask  <= pio_writedata[17:0];
            last_mask <= pio_writedata[17:0];
            mask_cnt  <= mask_cnt + 1;
        end
        if (pio_chipselect && !pio_write_n && pio_address == 2'd3) begin
            clr_cnt  <= clr_cnt + 1;
            edge_cap <= inject;
        end else begin
            edge_cap <= edge_cap | inject;
        end
    end

    assign pio_irq = (|(edge_cap & pio_mask)) | irq_force;

    always @(negedge clk) begin
        if (!reset && ev_valid && ev_ready) begin
            mon_r.index = ev_index;
            mon_r.level = ev_level;
            got.push_back(mon_r);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inject_edges(input logic [17:0] v);
        inject = v;
        tick();
        inject = '0;
    endtask

    // Reference: one event per captured bit, ascending index, level read after clear.
    task automatic build_exp(input logic [17:0] cap, input logic [17:0] lvl);
        ev_rec_t r;
        exp_q.delete();
        for (int i = 0; i < 18; i++) begin
            if (cap[i]) begin
                r.index = 5'(i);
                r.level = lvl[i];
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic wait_done(input int n_exp, input int budget, input bit rnd, input string tag);
        int k;
        for (k = 0; k < budget; k++) begin
            tick();
            ev_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (got.size() >= n_exp && !busy && !ev_valid) break;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL %s_timeout: got %0d events, expected %0d", tag, got.size(), n_exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({pio_chipselect, pio_write_n, pio_address, pio_writedata, ev_valid, busy} !==
            {1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: got cs=%b wn=%b a=%0d wd=%0h v=%b busy=%b expected 0 1 0 0 0 1",
                     pio_chipselect, pio_write_n, pio_address, pio_writedata, ev_valid, busy);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {1'b1, 1'b0, 2'd2, 32'h3FFFF}) begin
            errors++;
            $display("FAIL init_write: got cs=%b wn=%b a=%0d wd=%0h expected 1 0 2 3ffff",
                     pio_chipselect, pio_write_n, pio_address, pio_writedata);
        end
        tick();
        checks++;
        if ({busy, pio_chipselect, pio_address} !== {1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL init_idle: got busy=%b cs=%b a=%0d expected 0 0 0", busy, pio_chipselect, pio_address);
        end
    endtask

    task automatic test_basic();
        int k;
        int clr0 = clr_cnt;
        got.delete();
        ev_ready = 1'b1;
        sw_level = 18'h00001;
        build_exp(18'h00005, sw_level);
        inject_edges(18'h00005);
        for (k = 1; k < 20; k++) begin
            tick();
            if (ev_valid) break;
        end
        checks++;
        if (k != 7) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, expected 7", k);
        end
        wait_done(2, 50, 1'b0, "basic");
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_ev%0d: got idx=%0d lvl=%b expected idx=%0d lvl=%b",
                         i, got[i].index, got[i].level, exp_q[i].index, exp_q[i].level);
            end
        end
        checks++;
        if (clr_cnt - clr0 != 1) begin
            errors++;
            $display("FAIL basic_clr: got %0d clears expected 1", clr_cnt - clr0);
        end
    endtask

    task automatic test_enable();
        got.delete();
        enable = 1'b0;
        sw_level = 18'h00010;
        inject_edges(18'h00010);
        repeat (10) tick();
        checks++;
        if (busy !== 1'b0 || got.size() != 0) begin
            errors++;
            $display("FAIL enable_hold: got busy=%b events=%0d expected 0 0", busy, got.size());
        end
        enable = 1'b1;
        wait_done(1, 50, 1'b0, "enable");
        checks++;
        if (got.size() != 1 || got[0].index !== 5'd4 || got[0].level !== 1'b1) begin
            errors++;
            $display("FAIL enable_ev: got n=%0d expected one event idx=4 lvl=1", got.size());
        end
    endtask

    task automatic test_full_stall();
        int n;
        got.delete();
        ev_ready = 1'b0;
        sw_level = 18'h2A5C3;
        build_exp(18'h3FFFF, sw_level);
`ifdef SW_EVT_OVERFLOW_EN
        logic [15:0] d0 = ev_dropped;
        while (exp_q.size() > 8) void'(exp_q.pop_back());
`endif
        inject_edges(18'h3FFFF);
        repeat (30) tick();
        checks++;
`ifdef SW_EVT_OVERFLOW_EN
        if (busy !== 1'b0 || ev_valid !== 1'b1 || ev_dropped - d0 != 16'd10) begin
            errors++;
            $display("FAIL full_drop: got busy=%b valid=%b dropped=%0d expected 0 1 10", busy, ev_valid, ev_dropped - d0);
        end
`else
        if (busy !== 1'b1 || ev_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_stall: got busy=%b valid=%b expected 1 1", busy, ev_valid);
        end
`endif
        n = exp_q.size();
        wait_done(n, 200, 1'b0, "full");
        checks++;
        if (got.size() != n) begin
            errors++;
            $display("FAIL full_count: got %0d expected %0d", got.size(), n);
        end
        for (int i = 0; i < n && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_ev%0d: got idx=%0d lvl=%b expected idx=%0d lvl=%b",
                         i, got[i].index, got[i].level, exp_q[i].index, exp_q[i].level);
            end
        end
    endtask

    task automatic test_cfg_mask();
        int m0 = mask_cnt;
        got.delete();
        ev_ready = 1'b0;
        inject_edges(18'h3FFFF);
        repeat (12) tick();
        cfg_mask_wr = 1'b1;
        cfg_mask = 18'h00F00;
        tick();
        cfg_mask_wr = 1'b0;
        cfg_mask = 18'h12345;
        repeat (5) tick();
`ifndef SW_EVT_OVERFLOW_EN
        checks++;
        if (busy !== 1'b1 || mask_cnt != m0) begin
            errors++;
            $display("FAIL cfg_deferred: got busy=%b writes=%0d expected 1 0", busy, mask_cnt - m0);
        end
`endif
        wait_done(0, 200, 1'b0, "cfg");
        repeat (3) tick();
        checks++;
        if (mask_cnt - m0 != 1 || last_mask !== 18'h00F00) begin
            errors++;
            $display("FAIL cfg_applied: got writes=%0d mask=%0h expected 1 f00", mask_cnt - m0, last_mask);
        end
        cfg_mask_wr = 1'b1;
        cfg_mask = 18'h3FFFF;
        tick();
        cfg_mask_wr = 1'b0;
        repeat (4) tick();
        checks++;
        if (mask_cnt - m0 != 2 || last_mask !== 18'h3FFFF || busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_restore: got writes=%0d mask=%0h busy=%b expected 2 3ffff 0",
                     mask_cnt - m0, last_mask, busy);
        end
    endtask

    task automatic test_spurious();
        int nbusy = 0;
        int clr0 = clr_cnt;
        got.delete();
        ev_ready = 1'b1;
        irq_force = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            irq_force = 1'b0;
            if (busy) nbusy++;
        end
        checks++;
        if (nbusy != 6 || clr_cnt - clr0 != 1 || got.size() != 0) begin
            errors++;
            $display("FAIL spurious: got busy_cycles=%0d clears=%0d events=%0d expected 6 1 0",
                     nbusy, clr_cnt - clr0, got.size());
        end
    endtask

    task automatic test_random();
        logic [17:0] cap;
        for (int it = 0; it < 12; it++) begin
            got.delete();
            cap = 18'($urandom_range(1, 18'h3FFFF));
            sw_level = 18'($urandom);
            build_exp(cap, sw_level);
            inject_edges(cap);
`ifdef SW_EVT_OVERFLOW_EN
            wait_done(exp_q.size(), 400, 1'b0, "rand");
`else
            wait_done(exp_q.size(), 400, 1'b1, "rand");
`endif
            checks++;
            if (got.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d expected %0d (cap=%0h)", it, got.size(), exp_q.size(), cap);
            end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_ev%0d: got idx=%0d lvl=%b expected idx=%0d lvl=%b",
                             it, i, got[i].index, got[i].level, exp_q[i].index, exp_q[i].level);
                end
            end
        end
        ev_ready = 1'b1;
    endtask

    task automatic test_reset_in_emit();
        got.delete();
        ev_ready = 1'b0;
        inject_edges(18'h007FF);
        repeat (20) tick();
`ifndef SW_EVT_OVERFLOW_EN
        checks++;
        if (busy !== 1'b1 || ev_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_emit_pre: got busy=%b valid=%b expected 1 1", busy, ev_valid);
        end
`endif
        reset = 1'b1;
        tick();
        checks++;
        if ({pio_chipselect, pio_write_n, pio_address, pio_writedata, ev_valid, busy} !==
            {1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_emit_values: got cs=%b wn=%b a=%0d wd=%0h v=%b busy=%b expected 0 1 0 0 0 1",
                     pio_chipselect, pio_write_n, pio_address, pio_writedata, ev_valid, busy);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {1'b1, 1'b0, 2'd2, 32'h3FFFF}) begin
            errors++;
            $display("FAIL rst_emit_init: got cs=%b wn=%b a=%0d wd=%0h expected 1 0 2 3ffff",
                     pio_chipselect, pio_write_n, pio_address, pio_writedata);
        end
        ev_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (got.size() != 0 || busy !== 1'b0 || ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_emit_flush: got events=%0d busy=%b valid=%b expected 0 0 0", got.size(), busy, ev_valid);
        end
`ifdef SW_EVT_OVERFLOW_EN
        checks++;
        if (ev_dropped !== 16'd0) begin
            errors++;
            $display("FAIL rst_emit_dropped: got %0d expected 0", ev_dropped);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_enable();
        test_full_stall();
        test_cfg_mask();
        test_spurious();
        test_random();
        test_reset_in_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
